maze_key_scan: RTL and testbench
================================

Name: maze_key_scan

Overview:
- 4x4 matrix keypad scanner and debouncer; the input stage of the Maze game.
- Drives the active-low one-hot column strobe `key_col` and samples the active-low `key_row` lines.
- Produces a debounced key map plus a one-cycle `key_valid` pulse with a 4-bit `key_code`.
- The Maze game FSM consumes `key_code`/`key_valid` as player move commands.

Parameters:
- SCAN_DIV, 1000, clocks each column is held before advancing (>=2).
- DEBOUNCE_SCANS, 4, consecutive identical full frames required to accept a new key map (>=1).
- REPEAT_DELAY, 50, frames a key must be held before the first auto-repeat (used only with KEY_REPEAT_EN).
- REPEAT_RATE, 10, frames between subsequent auto-repeats (used only with KEY_REPEAT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- nst  input  1  reset, asynchronous, active-high.
- key_row  input  4  keypad row sense, active-low; bit r low = key in row r closed on the strobed column.
- key_col  output  4  column strobe, active-low one-hot; column c drives bit c low.
- key_code  output  4  index of reported key = col*4 + row.
- key_valid  output  1  one-cycle pulse; `key_code` is valid in the same cycle.
- key_pressed  output  1  debounced level: any key held.
- key_map  output  16  debounced pressed map, bit (col*4+row) = 1 when pressed.

Behaviour:
- Reset (async, while `nst`=1): `key_col`=4'b1110, `key_code`=0, `key_valid`=0, `key_pressed`=0, `key_map`=0. All counters, snapshot and debounce state are cleared. Reset mid-scan or mid-debounce discards the partial frame with no pulse. Scanning restarts at column 0 on the first clock after `nst` falls.
- Column timing:
  - Divider counts 0..SCAN_DIV-1 per column.
  - `key_row` is sampled into the raw snapshot on the last divider count of the column, giving SCAN_DIV-1 cycles of settle time.
  - `key_col` then advances 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wraps).
  - Frame = 4*SCAN_DIV clocks.
  - Inverted sample bits land at snapshot[col*4 +: 4].
- Frame end (the cycle column 3 is sampled): the complete 16-bit snapshot is compared with the previous frame's snapshot.
  - Mismatch: `stable_cnt` <= 1.
  - Match: `stable_cnt` increments, saturating at DEBOUNCE_SCANS.
  - When `stable_cnt` reaches DEBOUNCE_SCANS and the snapshot differs from `key_map`, `key_map` <= snapshot on the next clock.
  - With DEBOUNCE_SCANS=1, every frame is accepted.
- Event FSM, states IDLE / HELD:
  - IDLE -> HELD when the accepted `key_map` goes from 0 to nonzero. Same cycle as the `key_map` update: `key_valid`=1 for one clock, `key_code` = lowest set index.
  - HELD: additional or changed keys produce no pulse; `key_code` holds its value.
  - HELD -> IDLE when the accepted `key_map` becomes 0. No pulse on release.
  - If `key_map` goes directly from one nonzero set to another, stay in HELD with no pulse.
- `key_pressed` = |`key_map`, registered.
- `key_code` holds its last value after release and changes only on a pulse.
- Glitch or bounce shorter than DEBOUNCE_SCANS frames: no change to `key_map`, no pulse.
- Multiple simultaneous keys: report the lowest index only.
- Latency from a clean press (stable before the frame starts) to `key_valid`: DEBOUNCE_SCANS frames, plus the remainder of the current frame, plus 1 clock.

Optional Feature:
- KEY_REPEAT_EN.
- Defined: in HELD, a frame counter counts accepted-stable frames.
  - After REPEAT_DELAY frames, `key_valid` re-pulses with the current `key_code`.
  - It then re-pulses every REPEAT_RATE frames while still HELD.
  - Counter clears on entering HELD, on a `key_map` change, and on reset.
- Undefined: no repeat logic is present; one pulse per press.

Test Plan (SCAN_DIV=2, DEBOUNCE_SCANS=2, frame = 8 clocks):
- Reset: `nst` high for 2 clocks -> `key_col`=1110, `key_valid`=0, `key_map`=0. After release, `key_col` sequence is 1110,1110,1101,1101,1011,1011,0111,0111,1110.
- Single press: `key_row`=1011 whenever `key_col`=1101, 1111 otherwise, held from frame start. Required: exactly one `key_valid` pulse at the end of the 2nd full frame + 1 clock, with `key_code`=6, `key_map`=16'h0040, `key_pressed`=1.
- Release: all rows go to 1111 after the press. Required: `key_map`=0 and `key_pressed`=0 after 2 frames, no pulse, `key_code` stays 6.
- Bounce: key 6 asserted for 1 frame, released 1 frame, asserted again and held. Required: no pulse for the glitch, one pulse after 2 stable frames.
- Two keys: key 6 and key 13 (`key_col`=0111, `key_row`=1101) pressed together. Required: one pulse, `key_code`=6, `key_map`=16'h2040. Releasing key 6 only -> no pulse.
- Reset mid-debounce: `nst` pulsed after 1 stable frame of key 6. Required: outputs cleared, no pulse; the key is reported 2 full frames after reset release.

Source files
------------

// File: rtl/maze_key_scan.sv
// maze_key_scan: 4x4 matrix keypad scanner and debouncer for the Maze game.
//
// Walks an active-low one-hot strobe across the four columns, samples the
// active-low rows at the end of each column slot, and assembles a 16-bit
// snapshot per frame. A new key map is accepted only after DEBOUNCE_SCANS
// consecutive identical frames. An IDLE/HELD event FSM emits one key_valid
// pulse (with the lowest pressed index in key_code) on each new press.
//
// Optional feature macro: KEY_REPEAT_EN. When defined, a held key re-pulses
// key_valid after REPEAT_DELAY stable frames, then every REPEAT_RATE frames.
//
// Ports:
//   clk         system clock, rising edge
//   nst         asynchronous active-high reset
//   key_row     row sense, active-low
//   key_col     column strobe, active-low one-hot
//   key_code    reported key index (col*4 + row)
//   key_valid   one-cycle pulse qualifying key_code
//   key_pressed debounced "any key held" level
//   key_map     debounced 16-bit pressed map
module maze_key_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic        clk,
  input  logic        nst,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_pressed,
  output logic [15:0] key_map
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_FULL = STB_W'(DEBOUNCE_SCANS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  logic [DIV_W-1:0] div_cnt_r;
  logic [1:0]       col_idx_r;
  logic [3:0]       key_col_r;
  logic [15:0]      snap_r;
  logic [15:0]      prev_snap_r;
  logic [STB_W-1:0] stable_cnt_r;
  logic [15:0]      key_map_r;
  logic             key_pressed_r;
  logic [3:0]       key_code_r;
  logic             key_valid_r;
  state_t           state_r;

  logic             last_s;
  logic             frame_end_s;
  logic [15:0]      snap_next_s;
  logic [STB_W-1:0] stable_next_s;
  logic             accept_s;

  // Lowest set index of a key map; zero when the map is empty.
  function automatic logic [3:0] lowest_idx(input logic [15:0] map);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (map[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Slot timing and the frame snapshot including the column being sampled now.
  always_comb begin
    last_s      = (div_cnt_r == DIV_LAST);
    frame_end_s = last_s && (col_idx_r == 2'd3);
    snap_next_s = snap_r;
    snap_next_s[{col_idx_r, 2'b00} +: 4] = ~key_row;
  end

  // Debounce decision evaluated for the frame-end cycle.
  always_comb begin
    stable_next_s = 1'b1 ? STB_W'(1) : stable_cnt_r;
    if (snap_next_s == prev_snap_r) begin
      if (stable_cnt_r == STB_FULL) begin
        stable_next_s = stable_cnt_r;
      end else begin
        stable_next_s = stable_cnt_r + STB_W'(1);
      end
    end else begin
      stable_next_s = STB_W'(1);
    end
    accept_s = frame_end_s && (stable_next_s == STB_FULL) && (snap_next_s != key_map_r);
  end

  // Column scan, snapshot capture, debounce counter and accepted key map.
  always_ff @(posedge clk or posedge nst) begin
    if (nst) begin
      div_cnt_r     <= '0;
      col_idx_r     <= 2'd0;
      key_col_r     <= 4'b1110;
      snap_r        <= 16'h0000;
      prev_snap_r   <= 16'h0000;
      stable_cnt_r  <= '0;
      key_map_r     <= 16'h0000;
      key_pressed_r <= 1'b0;
    end else begin
      if (last_s) begin
        div_cnt_r <= '0;
        col_idx_r <= col_idx_r + 2'd1;
        snap_r    <= snap_next_s;
        case (col_idx_r)
          2'd0:    key_col_r <= 4'b1101;
          2'd1:    key_col_r <= 4'b1011;
          2'd2:    key_col_r <= 4'b0111;
          default: key_col_r <= 4'b1110;
        endcase
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
      if (frame_end_s) begin
        prev_snap_r  <= snap_next_s;
        stable_cnt_r <= stable_next_s;
      end
      if (accept_s) begin
        key_map_r     <= snap_next_s;
        key_pressed_r <= (snap_next_s != 16'h0000);
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_cnt_r;
  logic             rpt_armed_r;
`endif

  // Press event FSM: one pulse on 0 -> nonzero accepted map, none on release.
  always_ff @(posedge clk or posedge nst) begin
    if (nst) begin
      state_r     <= ST_IDLE;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
`ifdef KEY_REPEAT_EN
      rpt_cnt_r   <= '0;
      rpt_armed_r <= 1'b0;
`endif
    end else begin
      key_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && (snap_next_s != 16'h0000)) begin
            state_r     <= ST_HELD;
            key_valid_r <= 1'b1;
            key_code_r  <= lowest_idx(snap_next_s);
`ifdef KEY_REPEAT_EN
            rpt_cnt_r   <= '0;
            rpt_armed_r <= 1'b0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HELD: begin
          if (accept_s) begin
            state_r <= (snap_next_s == 16'h0000) ? ST_IDLE : ST_HELD;
`ifdef KEY_REPEAT_EN
            rpt_cnt_r   <= '0;
            rpt_armed_r <= 1'b0;
`endif
          end else begin
            state_r <= ST_HELD;
`ifdef KEY_REPEAT_EN
            // A non-accepting frame end at full stability means map is unchanged.
            if (frame_end_s && (stable_next_s == STB_FULL)) begin
              if ((!rpt_armed_r && (rpt_cnt_r + RPT_W'(1) == RPT_W'(REPEAT_DELAY))) ||
                  ( rpt_armed_r && (rpt_cnt_r + RPT_W'(1) == RPT_W'(REPEAT_RATE)))) begin
                key_valid_r <= 1'b1;
                rpt_cnt_r   <= '0;
                rpt_armed_r <= 1'b1;
              end else begin
                rpt_cnt_r <= rpt_cnt_r + RPT_W'(1);
              end
            end else begin
              rpt_cnt_r <= rpt_cnt_r;
            end
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign key_col     = key_col_r;
  assign key_code    = key_code_r;
  assign key_valid   = key_valid_r;
  assign key_pressed = key_pressed_r;
  assign key_map     = key_map_r;

endmodule

// File: tb/tb_maze_key_scan.sv
// Directed bench for maze_key_scan with SCAN_DIV=2, DEBOUNCE_SCANS=2
// (frame = 8 clocks). A keypad model turns the set of held keys into row
// levels for whichever column is strobed. All key changes happen right after
// a frame boundary so expected cycle counts are exact.
module tb_maze_key_scan;

  logic        clk;
  logic        nst;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] key_map;

  logic [15:0] keys_down;
  int          n_checks;
  int          n_errors;
  int          pulse_cnt;

  maze_key_scan #(
    .SCAN_DIV(2),
    .DEBOUNCE_SCANS(2),
    .REPEAT_DELAY(50),
    .REPEAT_RATE(10)
  ) dut (
    .clk(clk),
    .nst(nst),
    .key_row(key_row),
    .key_col(key_col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_pressed(key_pressed),
    .key_map(key_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: closed keys on the strobed column pull their rows low.
  always_comb begin
    key_row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!key_col[c]) begin
        key_row = ~keys_down[c*4 +: 4];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n clocks; sample #1 after each edge and count key_valid pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (key_valid) pulse_cnt++;
    end
  endtask

  logic [3:0] col_seq [0:8];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    pulse_cnt = 0;
    keys_down = 16'h0000;
    nst       = 1'b1;
    col_seq[0] = 4'b1110; col_seq[1] = 4'b1110; col_seq[2] = 4'b1101;
    col_seq[3] = 4'b1101; col_seq[4] = 4'b1011; col_seq[5] = 4'b1011;
    col_seq[6] = 4'b0111; col_seq[7] = 4'b0111; col_seq[8] = 4'b1110;

    // Reset state
    tick(2);
    check_val("rst_col", 32'(key_col), 32'h0000_000E);
    check_val("rst_valid", 32'(key_valid), 32'h0);
    check_val("rst_map", 32'(key_map), 32'h0);
    check_val("rst_pressed", 32'(key_pressed), 32'h0);
    check_val("rst_code", 32'(key_code), 32'h0);
    nst = 1'b0;

    // Column sequence over the first (empty) frame
    check_val("col_seq0", 32'(key_col), 32'(col_seq[0]));
    for (int k = 1; k < 9; k++) begin
      tick(1);
      check_val($sformatf("col_seq%0d", k), 32'(key_col), 32'(col_seq[k]));
    end

    // Single press of key 6, from a frame boundary
    keys_down = 16'h0040;
    tick(15);
    check_val("press_early_valid", 32'(key_valid), 32'h0);
    check_val("press_early_map", 32'(key_map), 32'h0);
    tick(1);
    check_val("press_valid", 32'(key_valid), 32'h1);
    check_val("press_code", 32'(key_code), 32'h6);
    check_val("press_map", 32'(key_map), 32'h0040);
    check_val("press_pressed", 32'(key_pressed), 32'h1);
    check_val("press_pulses", 32'(pulse_cnt), 32'h1);

    // Release
    keys_down = 16'h0000;
    tick(1);
    check_val("press_pulse_width", 32'(key_valid), 32'h0);
    tick(15);
    check_val("rel_map", 32'(key_map), 32'h0);
    check_val("rel_pressed", 32'(key_pressed), 32'h0);
    check_val("rel_code", 32'(key_code), 32'h6);
    check_val("rel_pulses", 32'(pulse_cnt), 32'h1);

    // Bounce: 1 frame on, 1 frame off, then held
    keys_down = 16'h0040;
    tick(8);
    keys_down = 16'h0000;
    tick(8);
    keys_down = 16'h0040;
    tick(15);
    check_val("bounce_no_pulse", 32'(pulse_cnt), 32'h1);
    check_val("bounce_map_hold", 32'(key_map), 32'h0);
    tick(1);
    check_val("bounce_valid", 32'(key_valid), 32'h1);
    check_val("bounce_pulses", 32'(pulse_cnt), 32'h2);

    // Two keys together: 6 and 13
    keys_down = 16'h0000;
    tick(16);
    check_val("two_pre_map", 32'(key_map), 32'h0);
    keys_down = 16'h2040;
    tick(16);
    check_val("two_valid", 32'(key_valid), 32'h1);
    check_val("two_code", 32'(key_code), 32'h6);
    check_val("two_map", 32'(key_map), 32'h2040);
    check_val("two_pulses", 32'(pulse_cnt), 32'h3);
    keys_down = 16'h2000;
    tick(16);
    check_val("drop6_map", 32'(key_map), 32'h2000);
    check_val("drop6_pulses", 32'(pulse_cnt), 32'h3);
    check_val("drop6_code", 32'(key_code), 32'h6);
    check_val("drop6_pressed", 32'(key_pressed), 32'h1);

    // Reset mid-debounce after one stable frame of key 6
    keys_down = 16'h0040;
    tick(8);
    check_val("mid_map", 32'(key_map), 32'h2000);
    nst = 1'b1;
    tick(2);
    check_val("mid_rst_col", 32'(key_col), 32'h0000_000E);
    check_val("mid_rst_map", 32'(key_map), 32'h0);
    check_val("mid_rst_pressed", 32'(key_pressed), 32'h0);
    check_val("mid_rst_code", 32'(key_code), 32'h0);
    check_val("mid_rst_pulses", 32'(pulse_cnt), 32'h3);
    nst = 1'b0;
    tick(15);
    check_val("post_rst_early", 32'(pulse_cnt), 32'h3);
    tick(1);
    check_val("post_rst_valid", 32'(key_valid), 32'h1);
    check_val("post_rst_code", 32'(key_code), 32'h6);
    check_val("post_rst_map", 32'(key_map), 32'h0040);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
